johnson_decoder: RTL
====================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the Johnson code width; legal range N >= 2.
REQ-002 The block SHALL have local width W = clog2(2N), giving the decoded index width (W = 3 for N = 4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: code is sampled on this cycle.
REQ-006 The block SHALL have port code, input, N bits: Johnson-coded word from the counter under test.
REQ-007 The block SHALL have port out_valid, output, 1 bit: index and flags describe the sample taken the previous cycle.
REQ-008 The block SHALL have port index, output, W bits: binary position of the last legal code.
REQ-009 The block SHALL have port code_err, output, 1 bit: previous sample was not a legal Johnson pattern.
REQ-010 The block SHALL have port seq_err, output, 1 bit: previous sample was legal but not the expected successor while locked.
REQ-011 The block SHALL have port locked, output, 1 bit: tracker is in state LOCKED.
REQ-012 The block SHALL have port err_count, output, 8 bits: saturating count of error samples.

Function
REQ-013 Legal patterns SHALL be the 2N states of a twisted-ring counter (bit0 loads ~bit[N-1], shift toward MSB), mapped as follows.
- k = 0..N: code = k low-order ones (0000 -> 0, 0001 -> 1, 0011 -> 2, 0111 -> 3, 1111 -> 4).
- k = N+1..2N-1: code = (2N-k) high-order ones, rest zero (1110 -> 5, 1100 -> 6, 1000 -> 7).
REQ-014 Any other pattern SHALL be illegal (e.g. 0101, 1001, 0010 for N = 4).
REQ-015 The successor of index k SHALL be (k+1) mod 2N; index 2N-1 wraps to 0.
REQ-016 Latency SHALL be one cycle: a sample with in_valid=1 at edge t produces out_valid=1 with its index and flags after edge t, held for exactly that cycle.
REQ-017 When in_valid=0, the next cycle SHALL show out_valid=0, code_err=0 and seq_err=0; index, state, reference and err_count SHALL hold.
REQ-018 On a legal sample, index SHALL update to the decoded value; on an illegal sample, index SHALL hold its prior value.
REQ-019 code_err and seq_err SHALL never both be 1 for the same sample.
REQ-020 The tracker SHALL have states UNLOCKED, ACQUIRE and LOCKED, stored with a reference index ref.
REQ-021 UNLOCKED transitions (valid samples only):
- legal: ref <= decoded, go to ACQUIRE;
- illegal: code_err=1, stay in UNLOCKED.
REQ-022 ACQUIRE transitions (valid samples only):
- legal successor of ref: go to LOCKED, ref <= decoded;
- legal non-successor: stay in ACQUIRE, ref <= decoded, no seq_err;
- illegal: code_err=1, go to UNLOCKED.
REQ-023 LOCKED transitions (valid samples only):
- successor: stay in LOCKED, ref <= decoded;
- legal non-successor, including a repeat of ref: seq_err=1, ref <= decoded, go to ACQUIRE;
- illegal: code_err=1, go to UNLOCKED.
REQ-024 locked SHALL be the registered state equal to LOCKED, updated on the same edge as out_valid.
REQ-025 err_count SHALL increment by 1 on each sample raising code_err or seq_err, and SHALL saturate at 255 (never wrap).
REQ-026 Gaps in in_valid SHALL NOT break lock; the successor check is against the last valid sample only.

Reset
REQ-027 Reset SHALL be synchronous: with reset=1 at a rising edge, the block SHALL set state=UNLOCKED, ref=0, index=0, out_valid=0, code_err=0, seq_err=0, locked=0, err_count=0.
REQ-028 Reset SHALL take priority over any in_valid sample on the same edge; that sample SHALL be discarded and produce no output.
REQ-029 Reset asserted mid-sequence while LOCKED SHALL drop locked on the next edge, and reacquisition SHALL require two valid legal samples again.
REQ-030 No output SHALL change asynchronously to clk.

Verification (N = 4)
REQ-031 Reset, then the sequence 0000, 0001, 0011, 0111 (in_valid=1 each cycle) -> index 0, 1, 2, 3; locked=1 from the second output onward; err_count=0.
REQ-032 Locked stream 1110, 1100, 1000, 0000 -> index 5, 6, 7, 0; wrap-around accepted; no errors; locked stays 1.
REQ-033 Locked at index 2, then sample 0101 -> code_err=1, index holds 2, locked=0, err_count=1; then 0111, 1111 -> relock at index 4.
REQ-034 Locked at index 3, then sample 0111 (repeat), then 1111 -> first sample gives seq_err=1, locked=0, err_count +1; second sample relocks.
REQ-035 300 consecutive illegal samples 1001 -> err_count reaches 255 and holds at 255; out_valid pulses once per sample.
REQ-036 Reset=1 coincident with in_valid=1 and code=0011 while locked -> next cycle all outputs zero and the sample produces no output; in_valid gap of 5 cycles mid-sequence -> out_valid=0 during the gap and lock retained.

Source files
------------

// File: rtl/johnson_decoder.sv
// Decodes a sampled Johnson (twisted-ring) counter word into its binary position and
// tracks whether successive samples follow the expected count sequence.
module johnson_decoder #(
   parameter int unsigned N = 4,
   localparam int unsigned W = $clog2(2 * N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [N-1:0] code,
   output logic         out_valid,
   output logic [W-1:0] index,
   output logic         code_err,
   output logic         seq_err,
   output logic         locked,
   output logic [7:0]   err_count
);

   localparam logic [1:0] StUnlocked = 2'd0;
   localparam logic [1:0] StAcquire  = 2'd1;
   localparam logic [1:0] StLocked   = 2'd2;

   localparam logic [W-1:0] LastIdx = W'(2 * N - 1);

   logic [1:0]   state_q, state_d;
   logic [W-1:0] ref_q, ref_d;
   logic [W-1:0] index_q, index_d;
   logic         out_valid_q, out_valid_d;
   logic         code_err_q, code_err_d;
   logic         seq_err_q, seq_err_d;
   logic [7:0]   err_count_q, err_count_d;

   logic         dec_legal;
   logic [W-1:0] dec_idx;
   logic [W-1:0] succ_idx;

   // Pattern k: k low ones for k <= N, otherwise ones from bit (k-N) upward.
   always_comb begin
      logic [N-1:0] pat;
      dec_legal = 1'b0;
      dec_idx   = '0;
      pat       = '0;
      for (int k = 0; k < 2 * N; k++) begin
         for (int i = 0; i < N; i++) begin
            pat[i] = (k <= N) ? (i < k) : (i >= k - N);
         end
         if (code == pat) begin
            dec_legal = 1'b1;
            dec_idx   = W'(k);
         end
      end
   end

   assign succ_idx = (ref_q == LastIdx) ? '0 : ref_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      index_d     = index_q;
      out_valid_d = 1'b0;
      code_err_d  = 1'b0;
      seq_err_d   = 1'b0;
      err_count_d = err_count_q;
      if (in_valid) begin
         out_valid_d = 1'b1;
         if (dec_legal) begin
            index_d = dec_idx;
            ref_d   = dec_idx;
         end
         case (state_q)
            StUnlocked: begin
               if (dec_legal) state_d = StAcquire;
               else           code_err_d = 1'b1;
            end
            StAcquire: begin
               if (!dec_legal) begin
                  code_err_d = 1'b1;
                  state_d    = StUnlocked;
               end else if (dec_idx == succ_idx) begin
                  state_d = StLocked;
               end
            end
            StLocked: begin
               if (!dec_legal) begin
                  code_err_d = 1'b1;
                  state_d    = StUnlocked;
               end else if (dec_idx != succ_idx) begin
                  seq_err_d = 1'b1;
                  state_d   = StAcquire;
               end
            end
            default: state_d = StUnlocked;
         endcase
         if ((code_err_d || seq_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StUnlocked;
         ref_q       <= '0;
         index_q     <= '0;
         out_valid_q <= 1'b0;
         code_err_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         index_q     <= index_d;
         out_valid_q <= out_valid_d;
         code_err_q  <= code_err_d;
         seq_err_q   <= seq_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign index     = index_q;
   assign code_err  = code_err_q;
   assign seq_err   = seq_err_q;
   assign locked    = (state_q == StLocked);
   assign err_count = err_count_q;

endmodule
